// File: rtl/lru_matrix_tracker_pkg.sv
// Shared helpers for the matrix-based true-LRU tracker.
// A recency matrix is held in a fixed-stride flat vector:
// bit (i*LRU_MAX_WAYS + j) = 1 means way i is more recent than way j.
package lru_pkg;

    localparam int unsigned LRU_MAX_WAYS = 16;
    localparam int unsigned LRU_MAT_W    = LRU_MAX_WAYS * LRU_MAX_WAYS;

    typedef logic [LRU_MAT_W-1:0] lru_mat_t;

    // Reset ordering: a higher way index is more recent, so way 0 starts as LRU.
    function automatic lru_mat_t lru_reset_matrix(input int unsigned ways);
        lru_mat_t m;
        m = '0;
        for (int unsigned i = 0; i < LRU_MAX_WAYS; i++) begin
            for (int unsigned j = 0; j < LRU_MAX_WAYS; j++) begin
                m[i*LRU_MAX_WAYS+j] = ((i < ways) && (j < ways) && (i > j)) ? 1'b1 : 1'b0;
            end
        end
        return m;
    endfunction

    // Touch: the way beats every other way (row set) and nobody beats it (column cleared).
    function automatic lru_mat_t lru_touch(input lru_mat_t m_in, input int unsigned way,
                                           input int unsigned ways);
        lru_mat_t m;
        m = m_in;
        for (int unsigned i = 0; i < LRU_MAX_WAYS; i++) begin
            for (int unsigned j = 0; j < LRU_MAX_WAYS; j++) begin
                if ((i < ways) && (j < ways) && (i != j)) begin
                    if (i == way) begin
                        m[i*LRU_MAX_WAYS+j] = 1'b1;
                    end else if (j == way) begin
                        m[i*LRU_MAX_WAYS+j] = 1'b0;
                    end else begin
                        m[i*LRU_MAX_WAYS+j] = m_in[i*LRU_MAX_WAYS+j];
                    end
                end else begin
                    m[i*LRU_MAX_WAYS+j] = m_in[i*LRU_MAX_WAYS+j];
                end
            end
        end
        return m;
    endfunction

    // Invalidate: the way beats nobody (row cleared) and every other way beats it (column set).
    function automatic lru_mat_t lru_invalidate(input lru_mat_t m_in, input int unsigned way,
                                                input int unsigned ways);
        lru_mat_t m;
        m = m_in;
        for (int unsigned i = 0; i < LRU_MAX_WAYS; i++) begin
            for (int unsigned j = 0; j < LRU_MAX_WAYS; j++) begin
                if ((i < ways) && (j < ways) && (i != j)) begin
                    if (i == way) begin
                        m[i*LRU_MAX_WAYS+j] = 1'b0;
                    end else if (j == way) begin
                        m[i*LRU_MAX_WAYS+j] = 1'b1;
                    end else begin
                        m[i*LRU_MAX_WAYS+j] = m_in[i*LRU_MAX_WAYS+j];
                    end
                end else begin
                    m[i*LRU_MAX_WAYS+j] = m_in[i*LRU_MAX_WAYS+j];
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lru_matrix_tracker_if.sv
// Access / invalidate / query bundle of the LRU tracker.
interface lru_matrix_tracker_if #(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned SETS      = 2,
    parameter int unsigned NUM_PORTS = 2,
    localparam int unsigned WAY_W    = $clog2(WAYS),
    localparam int unsigned SET_W    = (SETS > 1) ? $clog2(SETS) : 1
);
    logic [NUM_PORTS-1:0]            acc_v_i;
    logic [NUM_PORTS-1:0][SET_W-1:0] acc_set_i;
    logic [NUM_PORTS-1:0][WAY_W-1:0] acc_way_i;
    logic                            inv_v_i;
    logic [SET_W-1:0]                inv_set_i;
    logic [WAY_W-1:0]                inv_way_i;
    logic                            query_v_i;
    logic [SET_W-1:0]                query_set_i;
    logic [WAYS-1:0]                 lock_mask_i;
    logic                            victim_v_o;
    logic [WAY_W-1:0]                victim_way_o;
    logic                            all_locked_o;

    modport master (
        output acc_v_i, acc_set_i, acc_way_i, inv_v_i, inv_set_i, inv_way_i,
               query_v_i, query_set_i, lock_mask_i,
        input  victim_v_o, victim_way_o, all_locked_o
    );

    modport slave (
        input  acc_v_i, acc_set_i, acc_way_i, inv_v_i, inv_set_i, inv_way_i,
               query_v_i, query_set_i, lock_mask_i,
        output victim_v_o, victim_way_o, all_locked_o
    );
endinterface

// File: rtl/lru_matrix_tracker_victim_select.sv
// Victim candidate extraction and lowest-index priority encoder.

// A way is a candidate when it is unlocked and no unlocked way is older than it
// (its row, restricted to unlocked ways, is all zero).
module lru_victim_select #(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-1:0][WAYS-1:0] rows_i,
    input  logic [WAYS-1:0]           lock_mask_i,
    output logic [WAYS-1:0]           cand_o
);
    logic [WAYS-1:0] unlocked_s;

    assign unlocked_s = ~lock_mask_i;

    // Per-way candidate test over the unlocked subset.
    always_comb begin
        cand_o = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            cand_o[i] = unlocked_s[i] & ~(|(rows_i[i] & unlocked_s));
        end
    end
endmodule

// Lowest set bit wins; none_o flags an empty request vector.
module priority_encoder #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             none_o
);
    // Scan from the top down so the lowest requesting index is the last to write.
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            idx_o  = req_i[i] ? IDX_W'(i) : idx_o;
            none_o = req_i[i] ? 1'b0 : none_o;
        end
    end
endmodule

// File: rtl/lru_matrix_tracker.sv
// Multi-set, multi-port true-LRU tracker with a per-set recency matrix.
// Touches apply in port order, then the invalidate; the victim is
// computed from the pre-update state and registered one cycle later.
module lru_matrix_tracker
    import lru_pkg::*;
#(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned SETS      = 2,
    parameter int unsigned NUM_PORTS = 2,
    localparam int unsigned WAY_W    = $clog2(WAYS),
    localparam int unsigned SET_W    = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    lru_matrix_tracker_if.slave  bus
);
    typedef logic [WAYS-1:0][WAYS-1:0] way_mat_t;
    typedef logic [WAYS-1:0]           way_vec_t;

    lru_mat_t         m_r     [SETS];
    lru_mat_t         m_nxt_s [SETS];
    way_mat_t         rows_s;
    way_vec_t         cand_s;
    logic [WAY_W-1:0] pe_idx_s;
    logic             pe_none_s;
    logic [WAY_W-1:0] way_s;
    logic             all_locked_s;
    logic             victim_v_r;
    logic [WAY_W-1:0] victim_way_r;
    logic             all_locked_r;

    // Next matrix: each set folds in its own touches in port order, then the invalidate.
    always_comb begin
        for (int s = 0; s < int'(SETS); s++) begin
            m_nxt_s[s] = m_r[s];
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                m_nxt_s[s] = (bus.acc_v_i[p] && (bus.acc_set_i[p] == SET_W'(s)))
                           ? lru_touch(m_nxt_s[s], 32'(bus.acc_way_i[p]), WAYS)
                           : m_nxt_s[s];
            end
            m_nxt_s[s] = (bus.inv_v_i && (bus.inv_set_i == SET_W'(s)))
                       ? lru_invalidate(m_nxt_s[s], 32'(bus.inv_way_i), WAYS)
                       : m_nxt_s[s];
        end
    end

    // Recency state per set.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < int'(SETS); s++) begin
                m_r[s] <= lru_reset_matrix(WAYS);
            end
        end else begin
            for (int s = 0; s < int'(SETS); s++) begin
                m_r[s] <= m_nxt_s[s];
            end
        end
    end

    // Row vectors of the queried set, taken from the current (pre-update) state.
    always_comb begin
        rows_s = '0;
        for (int s = 0; s < int'(SETS); s++) begin
            for (int i = 0; i < int'(WAYS); i++) begin
                for (int j = 0; j < int'(WAYS); j++) begin
                    rows_s[i][j] = (bus.query_set_i == SET_W'(s))
                                 ? m_r[s][i*LRU_MAX_WAYS+j] : rows_s[i][j];
                end
            end
        end
    end

    lru_victim_select #(
        .WAYS        (WAYS)
    ) u_victim_select (
        .rows_i      (rows_s),
        .lock_mask_i (bus.lock_mask_i),
        .cand_o      (cand_s)
    );

    priority_encoder #(
        .WIDTH  (WAYS)
    ) u_priority_encoder (
        .req_i  (cand_s),
        .idx_o  (pe_idx_s),
        .none_o (pe_none_s)
    );

    assign all_locked_s = (bus.lock_mask_i == {WAYS{1'b1}});
    assign way_s        = pe_none_s ? {WAY_W{1'b0}} : pe_idx_s;

    // Registered victim result; way and all-locked hold between queries.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            victim_v_r   <= 1'b0;
            victim_way_r <= {WAY_W{1'b0}};
            all_locked_r <= 1'b0;
        end else begin
            victim_v_r <= bus.query_v_i;
            if (bus.query_v_i) begin
                victim_way_r <= way_s;
                all_locked_r <= all_locked_s;
            end else begin
                victim_way_r <= victim_way_r;
                all_locked_r <= all_locked_r;
            end
        end
    end

    assign bus.victim_v_o   = victim_v_r;
    assign bus.victim_way_o = victim_way_r;
    assign bus.all_locked_o = all_locked_r;
endmodule

// File: tb/tb_lru_matrix_tracker.sv
// Self-checking bench for lru_matrix_tracker: a recency-list model
// (index 0 = LRU) is compared against the DUT every cycle, plus
// directed scenarios pinned with hand-computed literal victims.
module tb_lru_matrix_tracker;
    localparam int WAYS  = 4;
    localparam int SETS  = 2;
    localparam int NP    = 2;
    localparam int WAY_W = 2;
    localparam int SET_W = 1;

    logic clk_i = 1'b0;
    logic reset_n_i;

    always #5 clk_i = ~clk_i;

    lru_matrix_tracker_if #(.WAYS(WAYS), .SETS(SETS), .NUM_PORTS(NP)) bus ();

    lru_matrix_tracker #(.WAYS(WAYS), .SETS(SETS), .NUM_PORTS(NP)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int ord [SETS][WAYS];
    int exp_way;
    int exp_al;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++)
            for (int k = 0; k < WAYS; k++) ord[s][k] = k;
        exp_way = 0;
        exp_al  = 0;
    endtask

    task automatic m_touch(input int s, input int w);
        int pos = 0;
        if (s < SETS) begin
            for (int k = 0; k < WAYS; k++) if (ord[s][k] == w) pos = k;
            for (int k = pos; k < WAYS - 1; k++) ord[s][k] = ord[s][k+1];
            ord[s][WAYS-1] = w;
        end
    endtask

    task automatic m_inv(input int s, input int w);
        int pos = 0;
        if (s < SETS) begin
            for (int k = 0; k < WAYS; k++) if (ord[s][k] == w) pos = k;
            for (int k = pos; k > 0; k--) ord[s][k] = ord[s][k-1];
            ord[s][0] = w;
        end
    endtask

    // Oldest unlocked way in the recency list; none left means all locked.
    task automatic m_victim(input int s, input logic [WAYS-1:0] mask, output int w, output int al);
        w  = 0;
        al = 1;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (!mask[ord[s][k]]) begin
                w  = ord[s][k];
                al = 0;
            end
        end
    endtask

    task automatic idle();
        bus.acc_v_i     = '0;
        bus.acc_set_i   = '0;
        bus.acc_way_i   = '0;
        bus.inv_v_i     = 1'b0;
        bus.inv_set_i   = '0;
        bus.inv_way_i   = '0;
        bus.query_v_i   = 1'b0;
        bus.query_set_i = '0;
        bus.lock_mask_i = '0;
    endtask

    task automatic touch(input int p, input int s, input int w);
        bus.acc_v_i[p]   = 1'b1;
        bus.acc_set_i[p] = SET_W'(s);
        bus.acc_way_i[p] = WAY_W'(w);
    endtask

    task automatic inval(input int s, input int w);
        bus.inv_v_i   = 1'b1;
        bus.inv_set_i = SET_W'(s);
        bus.inv_way_i = WAY_W'(w);
    endtask

    task automatic query(input int s, input logic [WAYS-1:0] mask);
        bus.query_v_i   = 1'b1;
        bus.query_set_i = SET_W'(s);
        bus.lock_mask_i = mask;
    endtask

    // One clock: advance the model from the sampled inputs, then compare #1 after the edge.
    task automatic cycle();
        int   w;
        int   al;
        logic qv;
        @(posedge clk_i);
        qv = bus.query_v_i;
        if (qv) begin
            m_victim(int'(bus.query_set_i), bus.lock_mask_i, w, al);
            exp_way = w;
            exp_al  = al;
        end
        for (int p = 0; p < NP; p++)
            if (bus.acc_v_i[p]) m_touch(int'(bus.acc_set_i[p]), int'(bus.acc_way_i[p]));
        if (bus.inv_v_i) m_inv(int'(bus.inv_set_i), int'(bus.inv_way_i));
        #1;
        check("victim_v", 32'(bus.victim_v_o), 32'(qv));
        check("victim_way", 32'(bus.victim_way_o), exp_way);
        check("all_locked", 32'(bus.all_locked_o), exp_al);
    endtask

    initial begin
        reset_n_i = 1'b0;
        idle();
        m_reset();
        #12;
        check("rst_victim_v", 32'(bus.victim_v_o), 0);
        check("rst_victim_way", 32'(bus.victim_way_o), 0);
        check("rst_all_locked", 32'(bus.all_locked_o), 0);
        reset_n_i = 1'b1;

        // First query after reset
        query(0, 4'b0000); cycle();
        check("lit_first_v", 32'(bus.victim_v_o), 1);
        check("lit_first_way", 32'(bus.victim_way_o), 0);
        check("lit_first_al", 32'(bus.all_locked_o), 0);

        // Set0 touches 0,1,2 then query; touch 3 then query
        idle(); touch(0, 0, 0); cycle();
        idle(); touch(0, 0, 1); cycle();
        idle(); touch(0, 0, 2); cycle();
        idle(); query(0, 4'b0000); cycle();
        check("lit_s0_after_012", 32'(bus.victim_way_o), 3);
        idle(); touch(0, 0, 3); cycle();
        idle(); query(0, 4'b0000); cycle();
        check("lit_s0_after_3", 32'(bus.victim_way_o), 0);

        // Set1: two ports in one cycle, then further touches; set0 unaffected
        idle(); touch(0, 1, 2); touch(1, 1, 1); cycle();
        idle(); query(1, 4'b0000); cycle();
        check("lit_s1_dual", 32'(bus.victim_way_o), 0);
        idle(); touch(0, 1, 0); cycle();
        idle(); touch(0, 1, 3); cycle();
        idle(); query(1, 4'b0000); cycle();
        check("lit_s1_after_03", 32'(bus.victim_way_o), 2);
        idle(); query(0, 4'b0000); cycle();
        check("lit_s0_isolated", 32'(bus.victim_way_o), 0);

        // Asynchronous reset pulse between edges while victim_v_o is high
        idle();
        #2 reset_n_i = 1'b0;
        #1;
        check("lit_async_rst_v", 32'(bus.victim_v_o), 0);
        check("lit_async_rst_way", 32'(bus.victim_way_o), 0);
        check("lit_async_rst_al", 32'(bus.all_locked_o), 0);
        #1 reset_n_i = 1'b1;
        m_reset();
        query(0, 4'b0000); cycle();
        check("lit_post_rst_s0", 32'(bus.victim_way_o), 0);
        idle(); query(1, 4'b0000); cycle();
        check("lit_post_rst_s1", 32'(bus.victim_way_o), 0);

        // Lock masks
        idle(); query(0, 4'b0001); cycle();
        check("lit_mask_0001", 32'(bus.victim_way_o), 1);
        idle(); query(0, 4'b1111); cycle();
        check("lit_mask_1111_al", 32'(bus.all_locked_o), 1);
        check("lit_mask_1111_way", 32'(bus.victim_way_o), 0);

        // Invalidate beats a same-cycle touch; same-cycle query sees old state
        for (int w = 0; w < WAYS; w++) begin
            idle(); touch(0, 0, w); cycle();
        end
        idle(); touch(0, 0, 3); inval(0, 3); cycle();
        idle(); query(0, 4'b0000); cycle();
        check("lit_inv_wins", 32'(bus.victim_way_o), 3);
        idle(); touch(0, 0, 3); query(0, 4'b0000); cycle();
        check("lit_query_old_state", 32'(bus.victim_way_o), 3);
        idle(); query(0, 4'b0000); cycle();
        check("lit_query_new_state", 32'(bus.victim_way_o), 0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 1) == 1)
                    touch(p, $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1));
            end
            if ($urandom_range(0, 5) == 0)
                inval($urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1));
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 7) == 0)
                    query($urandom_range(0, SETS - 1), 4'b1111);
                else if ($urandom_range(0, 1) == 0)
                    query($urandom_range(0, SETS - 1), 4'b0000);
                else
                    query($urandom_range(0, SETS - 1), 4'($urandom_range(0, 15)));
            end
            cycle();
        end
        idle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/lru_matrix_tracker.md
Name: lru_matrix_tracker

Overview:
- Parametrised, multi-set, multi-port true-LRU tracker based on a per-set WAYS×WAYS recency matrix.
- Serves set-associative lookup structures such as the key/round-key cache. Each set has its own replacement state.
- Applies all valid accesses in one cycle in port order, supports invalidation and a per-query lock mask, and returns a registered victim one cycle after a query.

Parameters:
- WAYS, 4, number of ways per set; must be ≥2 and a power of two.
- SETS, 2, number of independent sets; must be ≥1.
- NUM_PORTS, 2, number of access (touch) ports.
- WAY_W, $clog2(WAYS), derived; do not override.
- SET_W, max(1,$clog2(SETS)), derived; do not override.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- acc_v_i  in  NUM_PORTS  per-port access valid.
- acc_set_i  in  NUM_PORTS×SET_W  per-port set index.
- acc_way_i  in  NUM_PORTS×WAY_W  per-port way touched.
- inv_v_i  in  1  invalidate valid.
- inv_set_i  in  SET_W  invalidate set.
- inv_way_i  in  WAY_W  invalidate way.
- query_v_i  in  1  victim query valid.
- query_set_i  in  SET_W  queried set.
- lock_mask_i  in  WAYS  bit w=1 excludes way w from victim choice; sampled with query_v_i.
- victim_v_o  out  1  victim result valid.
- victim_way_o  out  WAY_W  chosen victim way.
- all_locked_o  out  1  every way was locked at query time.

Behaviour:
- State: m[s][i][j], one bit each. m[s][i][j]=1 means way i is more recent than way j. Diagonal bits are always 0.
- Reset (reset_n_i low, asynchronous): m[s][i][j]=1 iff i>j, for every set. This gives recency order 0 (LRU) … WAYS-1 (MRU).
- Reset values of outputs: victim_v_o=0, victim_way_o=0, all_locked_o=0.
- Touch of way a in set s: row a is set to all 1 except the diagonal; column a is cleared to 0. Way a becomes MRU.
- Invalidate of way w in set s: row w is cleared to 0; column w is set to 1 except the diagonal. Way w becomes LRU.
- Per-cycle update order: ports 0..NUM_PORTS-1 ascending, then the invalidate. Each step operates on the result of the previous step, so the highest-indexed port touching a set ends as MRU.
- An invalidate on the same set/way as a touch in the same cycle wins.
- Duplicate touches of the same way are idempotent.
- Accesses to different sets never interact.
- Out-of-range set indices (≥SETS) are ignored.
- Victim selection (combinational on the pre-update state of the query cycle):
  - U = ~lock_mask_i.
  - Candidate ways are those i with U[i]=1 and (m[s][i] & U)=0.
  - Pick the lowest-index candidate. There is exactly one unless the state is corrupt; the lowest index is the deterministic fallback.
  - If U=0: victim_way_o=0 and all_locked_o=1.
- Query latency:
  - victim_* is registered and valid in the cycle after query_v_i.
  - victim_v_o=query_v_i delayed one cycle; it holds 0 when no query.
  - victim_way_o and all_locked_o hold their last value when victim_v_o=0.
  - Back-to-back queries are supported at full rate.
- Same-cycle query and touch to the same set: the query sees the old state. A query in the following cycle sees the update.
- Reset asserted mid-operation: state and outputs return to reset values immediately. The first post-reset query returns way 0.
- No backpressure; all inputs are accepted every cycle.

Decomposition:
- Package lru_pkg:
  - Helper functions lru_touch(matrix,way) and lru_invalidate(matrix,way).
  - Reset-matrix constant function lru_reset_matrix(WAYS).
  - Packed types are parametric typedefs inside the module.
- Sub-module lru_victim_select (combinational): matrix row vectors + lock mask → candidate vector.
  - Feeds the existing priority_encoder for way index and all-locked flag.
  - Instantiated once, on the queried set's matrix.

Test Plan:
- Reset, query set0 mask 0000 → next cycle victim_v_o=1, victim_way_o=0, all_locked_o=0.
- Set0: touch 0, 1, 2 on port0 in consecutive cycles, then query → victim 3. Touch 3, then query → victim 0.
- Set1 after reset: in one cycle port0 touches 2 and port1 touches 1; query → victim 0. Then touch 0, touch 3, query → victim 2. Set0 is unaffected and its query → 0.
- After reset, query set0 with mask 0001 → victim 1. Mask 1111 → all_locked_o=1, victim_way_o=0.
- Set0: touch 0, 1, 2, 3, then in one cycle port0 touches 3 and invalidate hits set0 way3; query → victim 3. Same-cycle touch-plus-query of set0 way0 returns the pre-update victim.
- Mid-stream (after scenario 3) pulse reset_n_i low between clock edges → victim_v_o drops at once. After release, queries to set0 and set1 → victim 0.
